// File: rtl/led_pkg.sv
// Shared LED-path definitions: brightness level type and PWM slot count,
// common to the upstream triangle counter and the PWM level driver.
package led_pkg;

  localparam int LEVEL_W   = 4;
  localparam int PWM_SLOTS = 2 ** LEVEL_W;

  typedef logic [LEVEL_W-1:0] level_t;

endpackage : led_pkg

// File: rtl/pwm_level_driver_tick_gen.sv
// Prescaler: emits a one-cycle slot_tick every PRESCALE enabled clocks.
// Freezes (holds its count) while enable is low.
module tick_gen
  import led_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic slot_tick
);

  generate
    if (PRESCALE > 1) begin : g_cnt
      localparam int              CNT_W = $clog2(PRESCALE);
      localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

      logic [CNT_W-1:0] presc_cnt_q;
      logic [CNT_W-1:0] presc_cnt_d;

      // Next count: advance while enabled, wrap after the last prescale step.
      always_comb begin
        presc_cnt_d = presc_cnt_q;
        if (enable) begin
          presc_cnt_d = (presc_cnt_q == LAST) ? '0 : presc_cnt_q + 1'b1;
        end
      end

      // Prescale counter register, cleared asynchronously.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          presc_cnt_q <= '0;
        end else begin
          presc_cnt_q <= presc_cnt_d;
        end
      end

      assign slot_tick = enable & (presc_cnt_q == LAST);
    end else begin : g_pass
      // One clock per slot: every enabled clock is a slot boundary.
      assign slot_tick = enable;
    end
  endgenerate

endmodule : tick_gen

// File: rtl/pwm_level_driver.sv
// PWM level driver: turns the triangle counter's level into a breathing LED
// drive. The level is latched only at period wrap so the output never glitches
// on a mid-period change; the compare output is registered.
module pwm_level_driver #(
  parameter int PRESCALE   = 4,
  parameter int LEVEL_W    = led_pkg::LEVEL_W,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [LEVEL_W-1:0] level,
  output logic               pwm_out,
  output logic               period_start,
  output logic [LEVEL_W-1:0] duty_q
);

  import led_pkg::*;

  localparam logic [LEVEL_W-1:0] SLOT_LAST = {LEVEL_W{1'b1}};

  logic               slot_tick;
  logic               wrap;
  logic [LEVEL_W-1:0] slot_q;
  logic [LEVEL_W-1:0] slot_d;
  logic [LEVEL_W-1:0] duty_d;
  logic               period_start_q;
  logic               period_start_d;
  logic               pwm_q;
  logic               pwm_d;

  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .slot_tick (slot_tick)
  );

  assign wrap = slot_tick & (slot_q == SLOT_LAST);

  // Next state: slot advances on ticks, duty is resampled only at wrap, and
  // the compare uses the current registered slot/duty (one clock of latency).
  always_comb begin
    slot_d         = slot_q;
    duty_d         = duty_q;
    period_start_d = wrap;
    pwm_d          = ACTIVE_LOW ^ (slot_q < duty_q);
    if (slot_tick) begin
      slot_d = slot_q + 1'b1;
    end
    if (wrap) begin
      duty_d = level;
    end
  end

  // State registers; reset forces the inactive output level immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_q         <= '0;
      duty_q         <= '0;
      period_start_q <= 1'b0;
      pwm_q          <= ACTIVE_LOW;
    end else begin
      slot_q         <= slot_d;
      duty_q         <= duty_d;
      period_start_q <= period_start_d;
      pwm_q          <= pwm_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = period_start_q;

endmodule : pwm_level_driver

// File: tb/tb_pwm_level_driver.sv
// Scoreboard bench for pwm_level_driver: three instances (PRESCALE=1,
// PRESCALE=3, PRESCALE=1 active-low) run against a cycle model whose
// predictions are queued at drive time and compared after each edge.
module tb_pwm_level_driver;
  import led_pkg::*;

  logic   clock = 1'b0;
  logic   rst [3];
  logic   en  [3];
  level_t lvl [3];
  logic   pwm [3];
  logic   ps  [3];
  level_t duty[3];

  always #5 clock = ~clock;

  pwm_level_driver #(.PRESCALE(1), .LEVEL_W(4), .ACTIVE_LOW(1'b0)) dut_p1 (
    .clock(clock), .reset(rst[0]), .enable(en[0]), .level(lvl[0]),
    .pwm_out(pwm[0]), .period_start(ps[0]), .duty_q(duty[0]));

  pwm_level_driver #(.PRESCALE(3), .LEVEL_W(4), .ACTIVE_LOW(1'b0)) dut_p3 (
    .clock(clock), .reset(rst[1]), .enable(en[1]), .level(lvl[1]),
    .pwm_out(pwm[1]), .period_start(ps[1]), .duty_q(duty[1]));

  pwm_level_driver #(.PRESCALE(1), .LEVEL_W(4), .ACTIVE_LOW(1'b1)) dut_al (
    .clock(clock), .reset(rst[2]), .enable(en[2]), .level(lvl[2]),
    .pwm_out(pwm[2]), .period_start(ps[2]), .duty_q(duty[2]));

  typedef struct {
    int     inst;
    logic   pwm;
    logic   ps;
    level_t duty;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   n      = 0;
  int   hi1    = 0;
  int   hi3    = 0;
  int   hiL    = 0;
  int   last3  = -1;
  int   m_presc[3];
  int   m_slot [3];
  int   m_duty [3];

  function automatic int pres(input int i);
    return (i == 1) ? 3 : 1;
  endfunction

  function automatic logic al(input int i);
    return (i == 2) ? 1'b1 : 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, n);
    end
  endtask

  // Predict the outputs after the coming edge and advance the model state.
  task automatic model_step(input int i, output exp_t e);
    bit tick;
    e.inst = i;
    if (rst[i]) begin
      m_presc[i] = 0; m_slot[i] = 0; m_duty[i] = 0;
      e.pwm = al(i); e.ps = 1'b0; e.duty = '0;
    end else begin
      tick  = en[i] && (m_presc[i] == pres(i) - 1);
      e.pwm = al(i) ^ (m_slot[i] < m_duty[i]);
      e.ps  = tick && (m_slot[i] == 15);
      if (e.ps) m_duty[i] = int'(lvl[i]);
      if (tick) m_slot[i] = (m_slot[i] + 1) % 16;
      if (en[i]) m_presc[i] = (m_presc[i] == pres(i) - 1) ? 0 : m_presc[i] + 1;
      e.duty = level_t'(m_duty[i]);
    end
  endtask

  task automatic cyc();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      model_step(i, e);
      sbq.push_back(e);
    end
    @(posedge clock);
    #1;
    n++;
    for (int i = 0; i < 3; i++) begin
      e = sbq.pop_front();
      chk($sformatf("pwm_out[%0d]", e.inst), pwm[e.inst], e.pwm);
      chk($sformatf("period_start[%0d]", e.inst), ps[e.inst], e.ps);
      chk($sformatf("duty_q[%0d]", e.inst), duty[e.inst], e.duty);
    end
    if (pwm[0] === 1'b1) hi1++;
    if (pwm[1] === 1'b1) hi3++;
    if (pwm[2] === 1'b1) hiL++;
    if (ps[1] === 1'b1) begin
      if (last3 >= 0) chk("ps_spacing_p3", n - last3, 48);
      last3 = n;
    end
  endtask

  task automatic run(input int k);
    for (int c = 0; c < k; c++) cyc();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; en[i] = 1'b1; lvl[i] = '0;
      m_presc[i] = 0; m_slot[i] = 0; m_duty[i] = 0;
    end
    #2;
    run(2);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    lvl[0] = 4'd4; lvl[1] = 4'd2; lvl[2] = 4'd4;
    n = 0;

    // First period after reset is inactive; then 4 of 16 high.
    hi1 = 0;
    run(16);
    chk("first_period_dark", hi1, 0);
    hi1 = 0;
    run(32);
    chk("level4_high_count", hi1, 8);

    // PRESCALE=3, level=2: six high clocks per 48-clock period.
    hi3 = 0;
    run(48);
    chk("p3_high_count", hi3, 6);
    run(60);

    // level 0 never lights; level 15 lights 15 of 16.
    lvl[0] = 4'd0;
    run(48);
    hi1 = 0;
    run(16);
    chk("level0_high_count", hi1, 0);
    lvl[0] = 4'd15;
    run(32);
    hi1 = 0;
    run(16);
    chk("level15_high_count", hi1, 15);
    chk("duty15_visible", duty[0], 15);

    // Mid-period change 4 -> 9 at slot 7.
    lvl[0] = 4'd4;
    for (int k = 0; k < 64 && !(m_duty[0] == 4 && m_slot[0] == 7); k++) cyc();
    chk("reach_slot7", (m_duty[0] == 4 && m_slot[0] == 7), 1);
    lvl[0] = 4'd9;
    for (int k = 0; k < 32 && m_slot[0] != 15; k++) cyc();
    chk("duty_kept_4", duty[0], 4);
    cyc();
    chk("duty_now_9", duty[0], 9);
    hi1 = 0;
    run(16);
    chk("level9_high_count", hi1, 9);

    // Freeze at slot 2 with duty 4, then resume.
    lvl[0] = 4'd4;
    for (int k = 0; k < 64 && !(m_duty[0] == 4 && m_slot[0] == 2); k++) cyc();
    chk("reach_slot2", (m_duty[0] == 4 && m_slot[0] == 2), 1);
    en[0] = 1'b0;
    run(10);
    chk("frozen_pwm_high", pwm[0], 1);
    en[0] = 1'b1;
    hi1 = 0;
    run(14);
    chk("resume_high_count", hi1, 2);
    run(20);

    // Asynchronous reset during the active phase of the active-low instance.
    for (int k = 0; k < 40 && pwm[2] !== 1'b0; k++) cyc();
    chk("al_active_phase", pwm[2], 0);
    #3;
    rst[2] = 1'b1;
    #1;
    chk("async_pwm_inactive", pwm[2], 1);
    chk("async_duty_zero", duty[2], 0);
    chk("async_ps_zero", ps[2], 0);
    cyc();
    rst[2] = 1'b0;
    hiL = 0;
    run(16);
    chk("al_dark_period", hiL, 16);
    run(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pwm_level_driver
